// File: rtl/bpsk_rx_pkg.sv
// Shared types and constants for the BPSK receive frame controller.
package bpsk_rx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HUNT,
    LEN,
    PAYLOAD,
    CHECK
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_LEN,
    ERR_CSUM,
    ERR_TIMEOUT,
    ERR_OVERRUN
  } err_cause_t;

endpackage

// File: rtl/bpsk_sync_detect.sv
// Sync-word shift register with dual-polarity compare.
// The compare looks at the post-shift value so a match is known in the strobe cycle.
module bpsk_sync_detect #(
  parameter int                    SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = SYNC_WIDTH'(16'hA5C3)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift,
  input  logic bit_in,
  output logic match,
  output logic match_inv
);

  logic [SYNC_WIDTH-1:0] sr;
  logic [SYNC_WIDTH-1:0] sr_next;

  assign sr_next = {sr[SYNC_WIDTH-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (shift) begin
      sr <= sr_next;
    end
  end

  assign match     = shift && (sr_next == SYNC_WORD);
  assign match_inv = shift && (sr_next == ~SYNC_WORD);

endmodule

// File: rtl/bpsk_rx_frame_ctrl.sv
// BPSK receive sequencer: starts the demodulator, hunts sync in either polarity,
// frames a length-prefixed payload with an additive checksum and streams bytes out.
module bpsk_rx_frame_ctrl
  import bpsk_rx_pkg::*;
#(
  parameter int                    SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = SYNC_WIDTH'(16'hA5C3),
  parameter int                    MAX_LEN    = 64,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bit_valid,
  input  logic              bit_value,
  output logic              demod_start,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_error,
  output logic              inverted,
  output logic              busy,
  output err_cause_t        err_cause
);

  localparam int                TW       = $clog2(TIMEOUT + 1);
  // Loaded on the strobe edge so expiry lands exactly TIMEOUT cycles after the strobe.
  localparam logic [TW-1:0]     TMO_LOAD = TW'(TIMEOUT - 2);
  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

  rx_state_t         state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] remaining;
  logic [BYTE_W-1:0] checksum;
  logic [TW-1:0]     tmo;

  logic              match;
  logic              match_inv;
  logic              acc_bit;
  logic [BYTE_W-1:0] byte_in;
  rx_state_t         fail_state;

  bpsk_sync_detect #(
    .SYNC_WIDTH (SYNC_WIDTH),
    .SYNC_WORD  (SYNC_WORD)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != HUNT),
    .shift     ((state == HUNT) && enable && bit_valid),
    .bit_in    (bit_value),
    .match     (match),
    .match_inv (match_inv)
  );

  assign acc_bit    = bit_value ^ inverted;
  assign byte_in    = {shreg[BYTE_W-2:0], acc_bit};
  assign fail_state = enable ? HUNT : IDLE;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      remaining   <= '0;
      checksum    <= '0;
      tmo         <= '0;
      demod_start <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      inverted    <= 1'b0;
      err_cause   <= ERR_LEN;
    end else begin
      demod_start <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      if (byte_valid && byte_ready) byte_valid <= 1'b0;

      case (state)
        IDLE: if (enable) state <= START;
        START: begin
          demod_start <= 1'b1;
          state       <= HUNT;
        end
        HUNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (match || match_inv) begin
            inverted    <= !match;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
            shreg       <= '0;
            tmo         <= TMO_LOAD;
            state       <= LEN;
          end
        end
        LEN, PAYLOAD, CHECK: begin
          if (bit_valid) begin
            tmo     <= TMO_LOAD;
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == LEN) begin
                if (byte_in == '0 || byte_in > MAX_LEN_B) begin
                  frame_error <= 1'b1;
                  err_cause   <= ERR_LEN;
                  state       <= fail_state;
                end else begin
                  remaining <= byte_in;
                  checksum  <= '0;
                  state     <= PAYLOAD;
                end
              end else if (state == PAYLOAD) begin
                // A handshake completing this cycle frees the slot, so only a stalled sink overruns.
                if (byte_valid && !byte_ready) begin
                  frame_error <= 1'b1;
                  err_cause   <= ERR_OVERRUN;
                  state       <= fail_state;
                end else begin
                  byte_data  <= byte_in;
                  byte_valid <= 1'b1;
                  checksum   <= checksum + byte_in;
                  remaining  <= remaining - 1'b1;
                  if (remaining == 8'd1) state <= CHECK;
                end
              end else begin
                if (byte_in == checksum) begin
                  frame_end <= 1'b1;
                end else begin
                  frame_error <= 1'b1;
                  err_cause   <= ERR_CSUM;
                end
                state <= fail_state;
              end
            end
          end else if (tmo == '0) begin
            frame_error <= 1'b1;
            err_cause   <= ERR_TIMEOUT;
            state       <= fail_state;
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_rx_frame_ctrl.sv
// Directed bench for bpsk_rx_frame_ctrl: normal/inverted frames, length, checksum,
// overrun and timeout errors, and reset mid-payload.
module tb_bpsk_rx_frame_ctrl;
  import bpsk_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, bit_valid, bit_value, byte_ready;
  logic       demod_start, byte_valid, frame_start, frame_end, frame_error, inverted, busy;
  logic [7:0] byte_data;
  err_cause_t err_cause;

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_strobe = 0, err_cyc = 0;
  int n_start = 0, n_end = 0, n_ferr = 0, n_demod = 0;
  logic [7:0] got[$];
  int s_start, s_end, s_ferr, g0;

  bpsk_rx_frame_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .demod_start (demod_start),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_error (frame_error),
    .inverted    (inverted),
    .busy        (busy),
    .err_cause   (err_cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bit_valid) last_strobe = cyc;
    if (frame_start) n_start++;
    if (frame_end) n_end++;
    if (frame_error) begin n_ferr++; err_cyc = cyc; end
    if (demod_start) n_demod++;
    if (byte_valid && byte_ready) got.push_back(byte_data);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_valid = 1'b1;
    bit_value = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic inv);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i] ^ inv);
  endtask

  task automatic send_frame(input logic inv, input logic [7:0] len, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] cs);
    send_word(16'hA5C3, 16, inv);
    send_word({8'h00, len}, 8, inv);
    send_word({8'h00, b0}, 8, inv);
    send_word({8'h00, b1}, 8, inv);
    send_word({8'h00, cs}, 8, inv);
  endtask

  task automatic snap();
    s_start = n_start; s_end = n_end; s_ferr = n_ferr; g0 = got.size();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; bit_value = 1'b0; byte_ready = 1'b1;
    wait_cycles(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_byte_data", int'(byte_data), 0);
    chk("rst_pulses", int'({demod_start, frame_start, frame_end, frame_error}), 0);
    chk("rst_inverted", int'(inverted), 0);
    reset = 1'b0; enable = 1'b1;
    wait_cycles(4);
    chk("demod_start_once", n_demod, 1);
    chk("busy_hunt", int'(busy), 1);

    // normal polarity frame
    snap();
    send_frame(1'b0, 8'h02, 8'h11, 8'h22, 8'h33);
    wait_cycles(3);
    chk("t1_frame_start", n_start - s_start, 1);
    chk("t1_frame_end", n_end - s_end, 1);
    chk("t1_no_error", n_ferr - s_ferr, 0);
    chk("t1_nbytes", got.size() - g0, 2);
    chk("t1_byte0", int'(got[g0]), 'h11);
    chk("t1_byte1", int'(got[g0+1]), 'h22);
    chk("t1_inverted", int'(inverted), 0);

    // inverted polarity frame
    snap();
    send_frame(1'b1, 8'h02, 8'h11, 8'h22, 8'h33);
    wait_cycles(3);
    chk("t2_frame_end", n_end - s_end, 1);
    chk("t2_no_error", n_ferr - s_ferr, 0);
    chk("t2_nbytes", got.size() - g0, 2);
    chk("t2_byte0", int'(got[g0]), 'h11);
    chk("t2_byte1", int'(got[g0+1]), 'h22);
    chk("t2_inverted", int'(inverted), 1);

    // zero length and over-long length
    snap();
    send_word(16'hA5C3, 16, 1'b0);
    send_word(16'h0000, 8, 1'b0);
    wait_cycles(2);
    chk("t3_len0_error", n_ferr - s_ferr, 1);
    chk("t3_err_latency", err_cyc - last_strobe, 1);
    chk("t3_cause_len", int'(err_cause), int'(ERR_LEN));
    send_word(16'hA5C3, 16, 1'b0);
    send_word(16'h0041, 8, 1'b0);
    wait_cycles(2);
    chk("t3_len41_error", n_ferr - s_ferr, 2);
    chk("t3_starts", n_start - s_start, 2);
    chk("t3_no_bytes", got.size() - g0, 0);
    chk("t3_byte_valid", int'(byte_valid), 0);
    chk("t3_no_end", n_end - s_end, 0);
    chk("t3_busy", int'(busy), 1);

    // bad checksum
    snap();
    send_frame(1'b0, 8'h02, 8'h11, 8'h22, 8'h34);
    wait_cycles(3);
    chk("t4_nbytes", got.size() - g0, 2);
    chk("t4_byte0", int'(got[g0]), 'h11);
    chk("t4_byte1", int'(got[g0+1]), 'h22);
    chk("t4_error", n_ferr - s_ferr, 1);
    chk("t4_no_end", n_end - s_end, 0);
    chk("t4_cause_csum", int'(err_cause), int'(ERR_CSUM));

    // overrun with a stalled sink
    byte_ready = 1'b0;
    snap();
    send_word(16'hA5C3, 16, 1'b0);
    send_word(16'h0002, 8, 1'b0);
    send_word(16'h0011, 8, 1'b0);
    wait_cycles(2);
    chk("t5_first_valid", int'(byte_valid), 1);
    chk("t5_no_error_yet", n_ferr - s_ferr, 0);
    send_word(16'h0022, 8, 1'b0);
    wait_cycles(2);
    chk("t5_overrun_error", n_ferr - s_ferr, 1);
    chk("t5_cause_overrun", int'(err_cause), int'(ERR_OVERRUN));
    chk("t5_data_held", int'(byte_data), 'h11);
    chk("t5_valid_held", int'(byte_valid), 1);
    byte_ready = 1'b1;
    wait_cycles(2);
    chk("t5_drained", got.size() - g0, 1);
    chk("t5_drained_byte", int'(got[g0]), 'h11);
    snap();
    send_frame(1'b0, 8'h02, 8'h11, 8'h22, 8'h33);
    wait_cycles(3);
    chk("t5_rehunt_end", n_end - s_end, 1);

    // timeout after sync
    snap();
    send_word(16'hA5C3, 16, 1'b0);
    for (int i = 0; i < 1100 && n_ferr == s_ferr; i++) @(posedge clk);
    wait_cycles(1);
    chk("t6_timeout_error", n_ferr - s_ferr, 1);
    chk("t6_timeout_latency", err_cyc - last_strobe, 1024);
    chk("t6_cause_timeout", int'(err_cause), int'(ERR_TIMEOUT));

    // reset mid-payload
    byte_ready = 1'b0;
    snap();
    send_word(16'hA5C3, 16, 1'b1);
    send_word(16'h0002, 8, 1'b1);
    send_word(16'h0011, 8, 1'b1);
    send_word(16'h0005, 3, 1'b1);
    wait_cycles(1);
    chk("t7_pre_valid", int'(byte_valid), 1);
    chk("t7_pre_inverted", int'(inverted), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cycles(1);
    chk("t7_busy", int'(busy), 0);
    chk("t7_byte_valid", int'(byte_valid), 0);
    chk("t7_byte_data", int'(byte_data), 0);
    chk("t7_inverted", int'(inverted), 0);
    chk("t7_pulses", int'({demod_start, frame_start, frame_end, frame_error}), 0);
    reset = 1'b0; byte_ready = 1'b1;
    wait_cycles(2);
    chk("t7_no_error", n_ferr - s_ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
